decomp_stream_seq: RTL

DECOMP_STREAM_SEQ -- requirements
Module: decomp_stream_seq

---
 rtl/decomp_stream_seq.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decomp_stream_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decomp_stream_seq
//  Purpose  : Parses a compressed byte stream into literal/copy items. A
//             little-endian control word (CTRL_WIDTH bits) announces the kind
//             of each following item (bit i -> item i, 0 = literal,
//             1 = copy). Each item is issued to the decompressor once it is
//             not busy.
//  Options  : define DECOMP_SEQ_STATS_EN to add the lit_count/copy_count
//             saturating issue counters.
//  Revision : 1.0 - initial release
// ============================================================================
module decomp_stream_seq #(
  parameter int CTRL_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] dec_data,
  output logic        dec_ctrl,
  output logic        dec_valid,
  input  logic        dec_busy,
  output logic        block_done,
  output logic        fmt_err
`ifdef DECOMP_SEQ_STATS_EN
  ,
  output logic [15:0] lit_count,
  output logic [15:0] copy_count
`endif
);

  localparam int NBYTES = CTRL_WIDTH / 8;

  typedef enum logic [1:0] {
    S_CTRL    = 2'd0,
    S_ITEM_B0 = 2'd1,
    S_ITEM_B1 = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic                    r_cbyte;     // index of the next control byte
  logic [CTRL_WIDTH-1:0]   r_ctrl;      // remaining control bits, current item at bit 0
  logic [4:0]              r_cnt;       // items issued under the current control word
  logic [15:0]             r_data;
  logic                    r_dctrl;
  logic                    r_last;      // final byte of the pending item carried in_last

  logic [CTRL_WIDTH-1:0]   w_ctrl_word;
  logic                    w_accept;
  logic                    w_ctrl_final;
  logic [4:0]              w_cnt_inc;
  logic                    w_ctrl_byte;
  logic                    w_load_ctrl;
  logic                    w_empty;
  logic                    w_abort;
  logic                    w_load_lit;
  logic                    w_load_hi;
  logic                    w_load_lo;
  logic                    w_issue;

  assign in_ready     = !reset && (r_state != S_ISSUE);
  assign w_accept     = in_valid && in_ready;
  assign w_ctrl_final = (r_cbyte == 1'(NBYTES - 1));
  assign w_cnt_inc    = r_cnt + 5'd1;
  assign dec_data     = r_data;
  assign dec_ctrl     = r_dctrl;

  // The first control byte is parked until the second one completes the word.
  generate
    if (CTRL_WIDTH == 16) begin : g_ctrl16
      logic [7:0] r_ctrl_lo;

      // Holds the low control byte while waiting for the high byte.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_ctrl_lo <= 8'h00;
        end else if (w_ctrl_byte) begin
          r_ctrl_lo <= in_byte;
        end else if (w_abort) begin
          r_ctrl_lo <= 8'h00;
        end
      end

      assign w_ctrl_word = {in_byte, r_ctrl_lo};
    end else begin : g_ctrl8
      assign w_ctrl_word = in_byte;
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_CTRL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, output strobes and datapath action selects.
  always_comb begin
    w_state_next = r_state;
    dec_valid    = 1'b0;
    block_done   = 1'b0;
    fmt_err      = 1'b0;
    w_ctrl_byte  = 1'b0;
    w_load_ctrl  = 1'b0;
    w_empty      = 1'b0;
    w_abort      = 1'b0;
    w_load_lit   = 1'b0;
    w_load_hi    = 1'b0;
    w_load_lo    = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      S_CTRL: begin
        if (w_accept) begin
          if (w_ctrl_final) begin
            if (in_last) begin
              // Control word with nothing behind it: an empty block.
              block_done = 1'b1;
              w_empty    = 1'b1;
            end else begin
              w_load_ctrl  = 1'b1;
              w_state_next = S_ITEM_B0;
            end
          end else if (in_last) begin
            fmt_err = 1'b1;
            w_abort = 1'b1;
          end else begin
            w_ctrl_byte = 1'b1;
          end
        end
      end
      S_ITEM_B0: begin
        if (w_accept) begin
          if (r_ctrl[0]) begin
            if (in_last) begin
              // Copy item cut short after its first byte.
              fmt_err      = 1'b1;
              w_abort      = 1'b1;
              w_state_next = S_CTRL;
            end else begin
              w_load_hi    = 1'b1;
              w_state_next = S_ITEM_B1;
            end
          end else begin
            w_load_lit   = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ITEM_B1: begin
        if (w_accept) begin
          w_load_lo    = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!dec_busy) begin
          dec_valid  = 1'b1;
          w_issue    = 1'b1;
          block_done = r_last;
          if (r_last || (w_cnt_inc == 5'(CTRL_WIDTH))) begin
            w_state_next = S_CTRL;
          end else begin
            w_state_next = S_ITEM_B0;
          end
        end
      end
      default: begin
        w_state_next = S_CTRL;
      end
    endcase
  end

  // Control-byte position within the control word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cbyte <= 1'b0;
    end else if (w_ctrl_byte) begin
      r_cbyte <= r_cbyte + 1'b1;
    end else if (w_load_ctrl || w_empty || w_abort) begin
      r_cbyte <= 1'b0;
    end
  end

  // Control word and item counter: loaded at word completion, advanced per issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
      r_cnt  <= 5'd0;
    end else if (w_load_ctrl) begin
      r_ctrl <= w_ctrl_word;
      r_cnt  <= 5'd0;
    end else if (w_issue) begin
      r_ctrl <= r_ctrl >> 1;
      r_cnt  <= w_cnt_inc;
    end else if (w_abort) begin
      r_ctrl <= '0;
      r_cnt  <= 5'd0;
    end
  end

  // Pending item: assembled from the item bytes, held stable through ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= 16'h0000;
      r_dctrl <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load_lit) begin
      r_data  <= {8'h00, in_byte};
      r_dctrl <= 1'b0;
      r_last  <= in_last;
    end else if (w_load_hi) begin
      r_data[15:8] <= in_byte;
      r_dctrl      <= 1'b1;
    end else if (w_load_lo) begin
      r_data[7:0] <= in_byte;
      r_last      <= in_last;
    end else if (w_abort) begin
      r_data  <= 16'h0000;
      r_dctrl <= 1'b0;
      r_last  <= 1'b0;
    end
  end

`ifdef DECOMP_SEQ_STATS_EN
  logic [15:0] r_lit_cnt;
  logic [15:0] r_copy_cnt;

  // Saturating counts of issued literal and copy items.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lit_cnt  <= 16'h0000;
      r_copy_cnt <= 16'h0000;
    end else if (w_issue) begin
      if (!r_dctrl && (r_lit_cnt != 16'hFFFF)) begin
        r_lit_cnt <= r_lit_cnt + 16'd1;
      end
      if (r_dctrl && (r_copy_cnt != 16'hFFFF)) begin
        r_copy_cnt <= r_copy_cnt + 16'd1;
      end
    end
  end

  assign lit_count  = r_lit_cnt;
  assign copy_count = r_copy_cnt;
`endif

endmodule
`default_nettype wire
